// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and an SRAM-style port.
// Latency: none, wiring bundle only.
// Backpressure: request fields are held until data_addr_ok; completion is signalled by data_data_ok.
interface memory_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: data load/store, load alignment/extension, HI/LO registers, wb bundle.
// Latency: 1 cycle for non-memory or misaligned ops; memory ops take REQ + memory latency + DONE.
// Backpressure: mem_allow_in drops outside IDLE; the request is held until data_addr_ok.
module memory_stage #(
    parameter logic [31:0] HILO_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    input  logic        exe_reg_en,
    input  logic [5:0]  exe_reg_waddr,
    input  logic        exe_mem_read,
    input  logic        exe_mem_write,
    input  logic [1:0]  exe_mem_size,
    input  logic        exe_mem_unsigned,
    input  logic [31:0] alu_result_reg,
    input  logic [31:0] exe_store_data,
    input  logic        exe_double_en,
    input  logic [63:0] exe_MD_result,
    output logic        mem_allow_in,
    memory_stage_if.master dmem,
    output logic        mem_valid,
    output logic        mem_reg_en,
    output logic [5:0]  mem_reg_waddr,
    output logic [31:0] mem_result,
    output logic        mem_addr_err,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        mem_op;
    logic        misaligned;
    logic        rdata_cap;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;

    // Bundle captured at acceptance
    logic        pass_vld_q;   // non-memory or misaligned result presented next cycle
    logic [31:0] addr_q;
    logic        reg_en_q;
    logic [5:0]  waddr_q;
    logic        ld_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;

    // Held request fields and captured response
    logic        data_wr_q;
    logic [31:0] data_addr_q;
    logic [3:0]  data_wstrb_q;
    logic [31:0] data_wdata_q;
    logic [31:0] rdata_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign accept    = exe_valid && mem_allow_in;
    assign mem_op    = exe_mem_read || exe_mem_write;
    // Sizes 2 and 3 are both word accesses, hence the test on size[1]
    assign misaligned = mem_op &&
                        (((exe_mem_size == 2'd1) && alu_result_reg[0]) ||
                         (exe_mem_size[1] && (alu_result_reg[1:0] != 2'b00)));
    // Response can land in REQ together with the address handshake, or later in WAIT
    assign rdata_cap = ((state == REQ) && dmem.data_addr_ok && dmem.data_data_ok) ||
                       ((state == WAIT) && dmem.data_data_ok);

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: only aligned memory ops leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && mem_op && !misaligned) state_nxt = REQ;
            REQ:  if (dmem.data_addr_ok) state_nxt = dmem.data_data_ok ? DONE : WAIT;
            WAIT: if (dmem.data_data_ok) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte-lane enables and replicated store data for the incoming bundle
    always_comb begin
        wstrb_new = 4'h0;
        wdata_new = exe_store_data;
        case (exe_mem_size)
            2'd0:    wdata_new = {4{exe_store_data[7:0]}};
            2'd1:    wdata_new = {2{exe_store_data[15:0]}};
            default: wdata_new = exe_store_data;
        endcase
        if (exe_mem_write) begin
            case (exe_mem_size)
                2'd0:    wstrb_new = 4'b0001 << alu_result_reg[1:0];
                2'd1:    wstrb_new = alu_result_reg[1] ? 4'b1100 : 4'b0011;
                default: wstrb_new = 4'hF;
            endcase
        end
    end

    // Bundle/request capture; request fields only change on acceptance, so they stay stable in REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_vld_q   <= 1'b0;
            addr_q       <= 32'h0;
            reg_en_q     <= 1'b0;
            waddr_q      <= 6'h0;
            ld_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            data_wr_q    <= 1'b0;
            data_addr_q  <= 32'h0;
            data_wstrb_q <= 4'h0;
            data_wdata_q <= 32'h0;
            rdata_q      <= 32'h0;
        end else begin
            pass_vld_q <= accept && (!mem_op || misaligned);
            if (accept) begin
                addr_q   <= alu_result_reg;
                reg_en_q <= exe_reg_en;
                waddr_q  <= exe_reg_waddr;
                ld_q     <= exe_mem_read && !exe_mem_write;
                size_q   <= exe_mem_size;
                uns_q    <= exe_mem_unsigned;
                err_q    <= misaligned;
                if (mem_op && !misaligned) begin
                    data_wr_q    <= exe_mem_write;
                    data_addr_q  <= {alu_result_reg[31:2], 2'b00};
                    data_wstrb_q <= wstrb_new;
                    data_wdata_q <= wdata_new;
                end
            end
            if (rdata_cap) begin
                rdata_q <= dmem.data_rdata;
            end
        end
    end

    // HI/LO follow completed mult/div results regardless of the load/store FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= HILO_INIT;
            lo <= HILO_INIT;
        end else if (exe_double_en) begin
            hi <= exe_MD_result[63:32];
            lo <= exe_MD_result[31:0];
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'd0:    load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'd1:    load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    // Outputs decoded from state and captured bundle
    always_comb begin
        mem_allow_in     = (state == IDLE);
        dmem.data_req    = (state == REQ);
        dmem.data_wr     = data_wr_q;
        dmem.data_addr   = data_addr_q;
        dmem.data_wstrb  = data_wstrb_q;
        dmem.data_wdata  = data_wdata_q;
        mem_valid        = (state == DONE) || pass_vld_q;
        mem_addr_err     = pass_vld_q && err_q;
        mem_reg_waddr    = waddr_q;
        mem_reg_en       = 1'b0;
        mem_result       = addr_q;
        if (state == DONE) begin
            mem_reg_en = ld_q && reg_en_q;
            if (ld_q) mem_result = load_val;
        end else if (pass_vld_q) begin
            mem_reg_en = reg_en_q && !err_q;
        end
    end

endmodule
